uart_rx_core: RTL



---
 rtl/uart_rx_core.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with runtime baud divider, one-byte holding register, framing and overrun status.
module uart_rx_core (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_rx,
  input  logic        rx_en,
  input  logic [15:0] comp,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun,
  input  logic        clr_ovr,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic [15:0] cnt_q, cnt_d, comp_l_q, comp_l_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d, data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        rx_s, commit, half_hit, bit_hit;
  assign rx_s     = s2_q;
  assign half_hit = cnt_q == (comp_l_q >> 1) - 16'd1;
  assign bit_hit  = cnt_q == comp_l_q - 16'd1;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    comp_l_d = comp_l_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q & ~clr_ovr;
    commit   = 1'b0;
    case (state_q)
      IDLE: if (rx_en && !rx_s) begin
        comp_l_d = comp;
        cnt_d    = '0;
        state_d  = START;
      end
      START: begin
        cnt_d = half_hit ? '0 : cnt_q + 16'd1;
        idx_d = half_hit ? '0 : idx_q;
        if (half_hit) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_d = bit_hit ? '0 : cnt_q + 16'd1;
        if (bit_hit) begin
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          state_d        = (idx_q == 3'd7) ? STOP : DATA;
        end
      end
      default: begin
        cnt_d   = bit_hit ? '0 : cnt_q + 16'd1;
        commit  = bit_hit;
        state_d = bit_hit ? IDLE : STOP;
      end
    endcase
    // disabling mid-frame drops the partial byte; holding register is untouched
    if (!rx_en && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      commit  = 1'b0;
    end
    if (commit && (!valid_q || rx_ack)) begin
      data_d  = shreg_q;
      ferr_d  = ~rx_s;
      valid_d = 1'b1;
    end else if (commit) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ack) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      comp_l_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= uart_rx;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      comp_l_q <= comp_l_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
endmodule
